// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encodings, grant IDs
// and the grant-selection helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Data wins contention unless the instruction side has waited through
   // a full streak of data grants.
   function automatic logic pick_grant(input logic ir, input logic dr,
                                       input logic [3:0] streak,
                                       input logic [3:0] lim);
      if (dr && !(ir && (streak == lim)))
         return GNT_D;
      return GNT_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory (req/ack handshake)
// between an instruction-fetch port and a data port. Data has priority,
// limited by STARVE_LIM consecutive data grants while a fetch is pending.
// Optional feature macro MEM_ARB_PERF_EN adds per-port wait-cycle counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ready,
   input  logic                d_req,
   input  logic [DATA_W/8-1:0] d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ready,
   output logic                m_req,
   output logic [DATA_W/8-1:0] m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ack
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_i_wait,
   output logic [31:0]         perf_d_wait
`endif
);

   localparam int         BE_W = DATA_W / 8;
   localparam logic [3:0] LIM  = 4'(STARVE_LIM);

   state_t     state, next_state;
   logic       grant_vld;
   logic       grant_id;
   logic [3:0] streak;

   // Next state and grant selection. The IDLE cycle that carries a ready
   // pulse is a dead cycle: that requester's held req is treated as
   // consumed, and no grant is made at all, so both sides re-arbitrate
   // together on the following cycle.
   always_comb begin
      next_state = state;
      grant_vld  = 1'b0;
      grant_id   = GNT_I;
      case (state)
         ST_IDLE: begin
            if (!i_ready && !d_ready && (i_req || d_req)) begin
               grant_vld  = 1'b1;
               grant_id   = pick_grant(i_req, d_req, streak, LIM);
               next_state = (grant_id == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (m_ack)
               next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Registered memory-side request, requester responses and the
   // data-grant streak counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_req   <= 1'b0;
         m_we    <= '0;
         m_addr  <= '0;
         m_wdata <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         streak  <= '0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         if (grant_vld) begin
            m_req <= 1'b1;
            if (grant_id == GNT_D) begin
               m_addr  <= d_addr;
               m_we    <= d_we;
               m_wdata <= d_wdata;
               // Only data grants that bypass a waiting fetch extend the streak.
               if (i_req)
                  streak <= (streak == LIM) ? streak : streak + 4'd1;
               else
                  streak <= '0;
            end else begin
               m_addr  <= i_addr;
               m_we    <= '0;
               m_wdata <= '0;
               streak  <= '0;
            end
         end else if ((state == ST_BUSY_I || state == ST_BUSY_D) && m_ack) begin
            m_req <= 1'b0;
            if (state == ST_BUSY_I) begin
               i_rdata <= m_rdata;
               i_ready <= 1'b1;
            end else begin
               // Stores leave the load-data register untouched.
               if (m_we == {BE_W{1'b0}})
                  d_rdata <= m_rdata;
               d_ready <= 1'b1;
            end
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   // Wait-cycle counters: cycles with a pending request and no completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_i_wait <= '0;
         perf_d_wait <= '0;
      end else begin
         if (i_req && !i_ready)
            perf_i_wait <= perf_i_wait + 32'd1;
         if (d_req && !d_ready)
            perf_d_wait <= perf_d_wait + 32'd1;
      end
   end
`endif

endmodule
